// File: rtl/can_acf_pkg.sv
// Shared types for the CAN acceptance-filter scan controller.
package can_acf_pkg;

  localparam int FRAME_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/can_acf_match.sv
// Single filter-slot compare: masked ID equality gated by the slot enable.
module can_acf_match #(
  parameter int ID_W = 29
) (
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] flt_id,
  input  logic [ID_W-1:0] flt_mask,
  input  logic            en,
  output logic            hit
);

  assign hit = en & (((id ^ flt_id) & flt_mask) == '0);

endmodule

// File: rtl/can_acf_scan_ctrl.sv
// Acceptance-filter sequencer: latches a frame, scans filter slots one per clock,
// writes accepted frames to the RX FIFO and reports hit index, reject and overrun.
module can_acf_scan_ctrl
  import can_acf_pkg::*;
#(
  parameter  int NUM_FLT = 4,
  parameter  int ID_W    = 29,
  parameter  int ID_LSB  = 0,
  localparam int IDX_W   = $clog2(NUM_FLT)
) (
  input  logic                    i_sc_sys_clk,
  input  logic                    i_sc_reset_n,
  input  logic                    i_sc_rx_ready,
  input  logic [FRAME_W-1:0]      i_sc_rx_message,
  input  logic                    i_sc_rx_full,
  input  logic [NUM_FLT-1:0]      i_sc_uaf,
  input  logic [NUM_FLT*ID_W-1:0] i_sc_flt_id,
  input  logic [NUM_FLT*ID_W-1:0] i_sc_flt_mask,
  output logic                    o_sc_rx_w_en,
  output logic [FRAME_W-1:0]      o_sc_rx_fifo_w_data,
  output logic                    o_sc_acfbsy,
  output logic [IDX_W-1:0]        o_sc_hit_idx,
  output logic                    o_sc_reject,
  output logic                    o_sc_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLT - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] frame;
  logic               hit;

  // Slot configuration is read live every scan cycle from the currently indexed slot.
  can_acf_match #(
    .ID_W (ID_W)
  ) u_match (
    .id       (frame[ID_LSB +: ID_W]),
    .flt_id   (i_sc_flt_id[idx*ID_W +: ID_W]),
    .flt_mask (i_sc_flt_mask[idx*ID_W +: ID_W]),
    .en       (i_sc_uaf[idx]),
    .hit      (hit)
  );

  assign o_sc_rx_w_en        = (state == S_WRITE) & ~i_sc_rx_full;
  assign o_sc_acfbsy         = (state != S_IDLE);
  assign o_sc_rx_fifo_w_data = frame;

  always_ff @(posedge i_sc_sys_clk or negedge i_sc_reset_n) begin
    if (!i_sc_reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      frame        <= '0;
      o_sc_hit_idx <= '0;
      o_sc_reject  <= 1'b0;
      o_sc_overrun <= 1'b0;
    end else begin
      o_sc_reject  <= 1'b0;
      o_sc_overrun <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_sc_rx_ready) begin
            frame <= i_sc_rx_message;
            idx   <= '0;
            state <= (i_sc_uaf == '0) ? S_WRITE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (i_sc_rx_ready) o_sc_overrun <= 1'b1;
          if (hit) begin
            o_sc_hit_idx <= idx;
            state        <= S_WRITE;
          end else if (idx == LAST_IDX) begin
            o_sc_reject <= 1'b1;
            state       <= S_IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_WRITE: begin
          // A full FIFO and a frame arriving while busy both count as one lost-frame event.
          if (i_sc_rx_full || i_sc_rx_ready) o_sc_overrun <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_acf_scan_ctrl.sv
// Directed bench for can_acf_scan_ctrl with hand-computed per-cycle expectations.
module tb_can_acf_scan_ctrl;

  localparam int NUM_FLT = 4;
  localparam int ID_W    = 29;
  localparam int IDX_W   = 2;
  localparam int NCYC    = 8;
  localparam logic [ID_W-1:0] ONES = '1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    rx_ready = 1'b0;
  logic                    rx_full = 1'b0;
  logic [127:0]            rx_message = '0;
  logic [NUM_FLT-1:0]      uaf = '0;
  logic [NUM_FLT*ID_W-1:0] flt_id = '0;
  logic [NUM_FLT*ID_W-1:0] flt_mask = '0;
  logic                    rx_w_en;
  logic [127:0]            fifo_w_data;
  logic                    acfbsy;
  logic [IDX_W-1:0]        hit_idx;
  logic                    reject;
  logic                    overrun;

  int tests = 0;
  int fails = 0;
  int full_cyc = 0;
  int ready2_cyc = 0;
  logic [127:0] msg2 = '0;
  logic [NCYC:1] wen_v, rej_v, ovr_v, bsy_v;
  logic [127:0]  wd [1:NCYC];

  logic [127:0] m_a5, m_id123, m_7ff, m_12f, m_other;

  always #5 clk = ~clk;

  can_acf_scan_ctrl #(
    .NUM_FLT (NUM_FLT),
    .ID_W    (ID_W),
    .ID_LSB  (0)
  ) dut (
    .i_sc_sys_clk        (clk),
    .i_sc_reset_n        (rst_n),
    .i_sc_rx_ready       (rx_ready),
    .i_sc_rx_message     (rx_message),
    .i_sc_rx_full        (rx_full),
    .i_sc_uaf            (uaf),
    .i_sc_flt_id         (flt_id),
    .i_sc_flt_mask       (flt_mask),
    .o_sc_rx_w_en        (rx_w_en),
    .o_sc_rx_fifo_w_data (fifo_w_data),
    .o_sc_acfbsy         (acfbsy),
    .o_sc_hit_idx        (hit_idx),
    .o_sc_reject         (reject),
    .o_sc_overrun        (overrun)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [ID_W-1:0] id, input logic [ID_W-1:0] mask);
    flt_id[k*ID_W +: ID_W]   = id;
    flt_mask[k*ID_W +: ID_W] = mask;
  endtask

  // Ready is driven in cycle T; cycle T+n is sampled on its falling edge into bit n.
  task automatic run_frame(input logic [127:0] msg);
    @(posedge clk); #1;
    rx_message = msg;
    rx_ready   = 1'b1;
    for (int n = 1; n <= NCYC; n++) begin
      @(posedge clk); #1;
      rx_ready = (n == ready2_cyc);
      if (n == ready2_cyc) rx_message = msg2;
      rx_full = (n == full_cyc);
      @(negedge clk);
      wen_v[n] = rx_w_en;
      rej_v[n] = reject;
      ovr_v[n] = overrun;
      bsy_v[n] = acfbsy;
      wd[n]    = fifo_w_data;
    end
    rx_ready   = 1'b0;
    rx_full    = 1'b0;
    full_cyc   = 0;
    ready2_cyc = 0;
  endtask

  initial begin
    logic any_wen, any_rej, any_ovr, any_bsy;
    m_a5    = {16{8'hA5}};
    m_id123 = 128'hCAFE_0000_0000_0000_0000_0000_0000_0123;
    m_7ff   = 128'h1234_5678_0000_0000_0000_0000_0000_07FF;
    m_12f   = 128'h0BAD_0000_0000_0000_0000_0000_0000_012F;
    m_other = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_0123;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_w_en", rx_w_en, 0);
    check_val("rst_w_data", fifo_w_data, 0);
    check_val("rst_acfbsy", acfbsy, 0);
    check_val("rst_hit_idx", hit_idx, 0);
    check_val("rst_reject", reject, 0);
    check_val("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // 1: bypass
    uaf = 4'b0000;
    run_frame(m_a5);
    check_val("byp_wen", wen_v, 8'h01);
    check_val("byp_bsy", bsy_v, 8'h01);
    check_val("byp_rej", rej_v, 8'h00);
    check_val("byp_ovr", ovr_v, 8'h00);
    check_val("byp_wdata", wd[1], m_a5);

    // Back-to-back: second ready in the first idle cycle is accepted
    msg2 = m_other;
    ready2_cyc = 2;
    run_frame(m_a5);
    check_val("b2b_wen", wen_v, 8'h05);
    check_val("b2b_bsy", bsy_v, 8'h05);
    check_val("b2b_ovr", ovr_v, 8'h00);
    check_val("b2b_wdata", wd[3], m_other);

    // 2: only slot 2 enabled; disabled slot 0 would also match
    set_slot(0, 29'h123, ONES);
    set_slot(1, 29'h000, ONES);
    set_slot(2, 29'h123, ONES);
    set_slot(3, 29'h000, ONES);
    uaf = 4'b0100;
    run_frame(m_id123);
    check_val("s2_wen", wen_v, 8'h08);
    check_val("s2_bsy", bsy_v, 8'h0F);
    check_val("s2_rej", rej_v, 8'h00);
    check_val("s2_wdata", wd[4], m_id123);
    check_val("s2_hit_idx", hit_idx, 2);

    // 3: all enabled, none match
    set_slot(0, 29'h001, ONES);
    set_slot(1, 29'h002, ONES);
    set_slot(2, 29'h003, ONES);
    set_slot(3, 29'h004, ONES);
    uaf = 4'b1111;
    run_frame(m_7ff);
    check_val("nm_wen", wen_v, 8'h00);
    check_val("nm_rej", rej_v, 8'h10);
    check_val("nm_bsy", bsy_v, 8'h0F);
    check_val("nm_ovr", ovr_v, 8'h00);
    check_val("nm_hit_idx", hit_idx, 2);

    // 4: masked match on slot 0; slot 1 also matches but lowest wins
    set_slot(0, 29'h120, 29'h1FFFFFF0);
    set_slot(1, 29'h12F, ONES);
    run_frame(m_12f);
    check_val("msk_wen", wen_v, 8'h02);
    check_val("msk_bsy", bsy_v, 8'h03);
    check_val("msk_rej", rej_v, 8'h00);
    check_val("msk_hit_idx", hit_idx, 0);

    // 5a: FIFO full during write
    full_cyc = 2;
    run_frame(m_12f);
    check_val("full_wen", wen_v, 8'h00);
    check_val("full_ovr", ovr_v, 8'h04);
    check_val("full_rej", rej_v, 8'h00);

    // 5b: second ready during scan is dropped
    set_slot(0, 29'h123, ONES);
    set_slot(2, 29'h123, ONES);
    uaf = 4'b0100;
    msg2 = m_other;
    ready2_cyc = 2;
    run_frame(m_id123);
    check_val("busy_ovr", ovr_v, 8'h04);
    check_val("busy_wen", wen_v, 8'h08);
    check_val("busy_wdata", wd[4], m_id123);
    check_val("busy_hit_idx", hit_idx, 2);

    // 6: reset while scanning slot 1
    uaf = 4'b1111;
    @(posedge clk); #1;
    rx_message = m_7ff;
    rx_ready   = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_bsy", acfbsy, 0);
    check_val("mid_rst_wdata", fifo_w_data, 0);
    check_val("mid_rst_hit_idx", hit_idx, 0);
    check_val("mid_rst_wen", rx_w_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_wen = 1'b0; any_rej = 1'b0; any_ovr = 1'b0; any_bsy = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      any_wen |= rx_w_en;
      any_rej |= reject;
      any_ovr |= overrun;
      any_bsy |= acfbsy;
    end
    check_val("post_rst_wen", any_wen, 0);
    check_val("post_rst_rej", any_rej, 0);
    check_val("post_rst_ovr", any_ovr, 0);
    check_val("post_rst_bsy", any_bsy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
